sprite_loader: RTL and testbench
================================

# sprite_loader

Write-side companion to the sprite texture memory. It receives sprite pixel data over a mode-0 SPI slave link, frames it with a command and start address, and drives a single write port into the 64x64 sprite RAM. Write addresses use the same `{col,row}` packing the renderer uses on the read side: row/Y scans first, then col/X. Data can therefore be loaded from an external MCU or host at runtime instead of from a preloaded hex image.

## Interface
Parameters:
- `CHANNEL_BITS`, default 2: bits per colour channel; stored pixel width is `3*CHANNEL_BITS`.
- `CMD_LOAD`, default 8'h50: command byte that opens a load transaction.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `spi_sclk`  in  1  SPI clock; asynchronous to `clk`.
- `spi_mosi`  in  1  SPI data, MSB first.
- `spi_csb`  in  1  SPI chip select, active low.
- `wr_en`  out  1  one-cycle write strobe to the sprite RAM.
- `wr_addr`  out  12  write address = `{col[5:0], row[5:0]}`.
- `wr_data`  out  `3*CHANNEL_BITS`  pixel value: the low bits of the received byte.
- `busy`  out  1  high while a transaction is open (CSb low, after sync).
- `done`  out  1  one-cycle pulse at CSb release if at least one pixel was written.

## Operation
- Input synchronisation: `spi_sclk`, `spi_mosi` and `spi_csb` each pass through 2-FF synchronisers.
- Edge detection: a third register stage on `spi_sclk` gives a rising-edge detect. MOSI is sampled on that detected rising edge.
- Byte assembly: 8-bit shift register plus 3-bit bit counter. After the 8th sampled bit, the completed byte is handed to the FSM and the bit counter clears.
- The FSM advances only on completed bytes. States and transitions:
  - IDLE: on synced CSb falling, clear the shifter and go to CMD.
  - CMD: if byte == `CMD_LOAD`, go to ADDR_HI; otherwise go to IGNORE.
  - ADDR_HI: `addr[11:8] <= byte[3:0]`; byte[7:4] is ignored. Go to ADDR_LO.
  - ADDR_LO: `addr[7:0] <= byte`. Go to DATA.
  - DATA: each byte writes one pixel. Then `addr <= addr + 1`, modulo 4096, so 4095 wraps to 0.
  - IGNORE: discard all bytes until CSb rises.
- Synced CSb high in any non-IDLE state returns the FSM to IDLE. A partial byte in the shifter is discarded. `done` pulses only if the state was DATA and at least one write occurred in this transaction.
- `busy` = state != IDLE.
- Reset (`reset_n` low on a clock edge), including mid-transaction:
  - All state clears and the FSM goes to IDLE.
  - `wr_en`, `done` and `busy` go to 0; `wr_addr` and `wr_data` go to 0.
  - The synchronisers reset to idle levels: sclk 0, csb 1.
  - If CSb is still low after reset releases, the rest of that transaction is ignored until CSb rises and falls again.

## Timing
- Input latency: 2 `clk` cycles of synchronisation plus 1 cycle of edge detection.
- SCLK limits: `spi_sclk` high and low periods must each be at least 3 `clk` cycles. Faster SCLK is outside the contract.
- Write timing: in DATA, `wr_en` is high for exactly 1 cycle, the cycle after the 8th-bit sample. `wr_addr` and `wr_data` are registered and valid in the same cycle. The address increment becomes visible on the next cycle.
- Write ordering: at most one write per 8 SCLK periods, so there is no back-pressure and no write can be lost.
- `done` is asserted 1 cycle after synced CSb high is detected. It is never asserted at the same time as `wr_en`.
- CSb release and the 8th bit on the same cycle: the byte is completed and written first. CSb release is handled on the following cycle.

## Test plan
- Basic load: CSb low, send 0x50, 0x02, 0x40, then 0x3F, 0x15, then CSb high. Expect `wr_en` twice: addr 0x240 with data 0x3F, then addr 0x241 with data 0x15. Then `done` pulses once.
- Wrap-around: send 0x50, 0x0F, 0xFF, then 0x01, 0x02. Expect writes at 0xFFF (data 0x01) and 0x000 (data 0x02).
- Bad command: send 0x51, 0x00, 0x00, 0x2A. Expect no `wr_en` and no `done`; `busy` stays high until CSb is released.
- Abort mid-byte: send 0x50, 0x00, 0x10, 0xAA, then 4 bits of the next byte, then CSb high. Expect one write at 0x010 with data 0x2A, partial byte dropped, `done` pulsed once.
- Reset mid-transaction: assert `reset_n` low for 2 cycles during the DATA phase. Expect all outputs 0 on the next edge. Further bytes while CSb stays low produce no writes. A fresh CSb low/high transaction then loads correctly.
- Full-frame load: write 4096 bytes of value (addr & 0x3F) from address 0. Then read the RAM back at `{col,row}`: every location must equal `row`, confirming Y-first ordering.

Source files
------------

// File: rtl/sprite_loader.sv
// SPI-slave loader for the 64x64 sprite RAM: frames a command byte and a 12-bit
// start address, then writes one pixel per received byte at {col,row} addresses.
module sprite_loader #(
  parameter int          CHANNEL_BITS = 2,
  parameter logic [7:0]  CMD_LOAD     = 8'h50
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      spi_sclk,
  input  logic                      spi_mosi,
  input  logic                      spi_csb,
  output logic                      wr_en,
  output logic [11:0]               wr_addr,
  output logic [3*CHANNEL_BITS-1:0] wr_data,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state_o
);

  localparam int PW = 3 * CHANNEL_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    DATA    = 3'd4,
    IGNORE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic           mosi_s1_q, mosi_s2_q;
  logic           csb_s1_q, csb_s2_q;
  logic [1:0]     settle_q, settle_d;
  logic           armed_q, armed_d;
  logic [6:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [11:0]    addr_q, addr_d;
  logic           wrote_q, wrote_d;
  logic           wr_en_q, wr_en_d;
  logic [11:0]    wr_addr_q, wr_addr_d;
  logic [PW-1:0]  wr_data_q, wr_data_d;
  logic           done_q, done_d;

  logic           sclk_rise, start, shift_en, byte_done;
  logic [7:0]     rx_byte;

  // A transaction may only open after CSb has been seen high once the
  // synchronisers hold real pin values; this drops a CSb-low that spans reset.
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign start     = (state_q == IDLE) && armed_q && !csb_s2_q;
  assign shift_en  = (state_q != IDLE) || start;
  assign byte_done = shift_en && sclk_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q, mosi_s2_q};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrote_d   = wrote_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d   = (settle_q == 2'd2) && csb_s2_q;

    if (!shift_en) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[5:0], mosi_s2_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // A completed byte wins over CSb release; the release is seen next cycle.
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CMD;
        wrote_d = 1'b0;
      end
    end else if (byte_done) begin
      case (state_q)
        CMD:     state_d = (rx_byte == CMD_LOAD) ? ADDR_HI : IGNORE;
        ADDR_HI: begin
          addr_d[11:8] = rx_byte[3:0];
          state_d      = ADDR_LO;
        end
        ADDR_LO: begin
          addr_d[7:0] = rx_byte;
          state_d     = DATA;
        end
        DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_byte[PW-1:0];
          addr_d    = addr_q + 12'd1;
          wrote_d   = 1'b1;
        end
        default: ;
      endcase
    end else if (csb_s2_q) begin
      state_d = IDLE;
      done_d  = (state_q == DATA) && wrote_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      csb_s1_q  <= 1'b1;
      csb_s2_q  <= 1'b1;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      wrote_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_s1_q <= spi_sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      csb_s1_q  <= spi_csb;
      csb_s2_q  <= csb_s1_q;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      wrote_q   <= wrote_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  // wr_en is a valid-only strobe: the RAM has no ready and must take every write.
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Bench for sprite_loader: SPI bit-bang driver, write scoreboard with a RAM
// model, table of single-pixel loads plus hand-written corner-case sequences.
module tb_sprite_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_sclk, spi_mosi, spi_csb;
  logic        wr_en, busy, done;
  logic [11:0] wr_addr;
  logic [5:0]  wr_data;
  logic [2:0]  dbg_state;

  sprite_loader #(.CHANNEL_BITS(2), .CMD_LOAD(8'h50)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_csb(spi_csb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [17:0] exp_q[$];
  logic [5:0]  ram_model[4096];

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  px;
    logic [11:0] exp_addr;
    logic [5:0]  exp_data;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        check("write_addr_data", {14'd0, wr_addr, wr_data}, {14'd0, exp_q.pop_front()});
      end
      ram_model[wr_addr] = wr_data;
    end
    if (done) begin
      done_cnt++;
      check("done_not_with_wr_en", {31'd0, wr_en}, 32'd0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [11:0] a, input logic [5:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input bit release_last);
    int h;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi_mosi = b[i];
      spi_sclk = 1'b0;
      h = $urandom_range(3, 5);
      repeat (h) @(negedge clk);
      spi_sclk = 1'b1;
      if (release_last && i == 0) spi_csb = 1'b1;
      repeat (h) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8, 1'b0);
  endtask

  task automatic csb_low();
    @(negedge clk);
    spi_csb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_txn(input string name, input int d0, input int exp_done);
    @(negedge clk);
    spi_csb = 1'b1;
    repeat (10) @(negedge clk);
    check({name, "_done_count"}, done_cnt - d0, exp_done);
    check({name, "_writes_drained"}, exp_q.size(), 0);
    check({name, "_busy_clear"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wr_en"},   {31'd0, wr_en},   32'd0);
    check({name, "_wr_addr"}, {20'd0, wr_addr}, 32'd0);
    check({name, "_wr_data"}, {26'd0, wr_data}, 32'd0);
    check({name, "_busy"},    {31'd0, busy},    32'd0);
    check({name, "_done"},    {31'd0, done},    32'd0);
    check({name, "_state"},   {29'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{hi: 8'h02, lo: 8'h40, px: 8'h3F, exp_addr: 12'h240, exp_data: 6'h3F};
    vecs[1] = '{hi: 8'hF5, lo: 8'hA5, px: 8'hC3, exp_addr: 12'h5A5, exp_data: 6'h03};
    vecs[2] = '{hi: 8'h0F, lo: 8'hFF, px: 8'hFF, exp_addr: 12'hFFF, exp_data: 6'h3F};
    vecs[3] = '{hi: 8'h00, lo: 8'h00, px: 8'h80, exp_addr: 12'h000, exp_data: 6'h00};
    vecs[4] = '{hi: 8'h0A, lo: 8'h5A, px: 8'h55, exp_addr: 12'hA5A, exp_data: 6'h15};

    reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_csb  = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic two-pixel load
    d0 = done_cnt;
    csb_low();
    check("basic_busy_open", {31'd0, busy}, 32'd1);
    spi_byte(8'h50); spi_byte(8'h02); spi_byte(8'h40);
    push_exp(12'h240, 6'h3F); push_exp(12'h241, 6'h15);
    spi_byte(8'h3F); spi_byte(8'h15);
    finish_txn("basic", d0, 1);

    // Table of single-pixel loads
    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      csb_low();
      spi_byte(8'h50); spi_byte(vecs[v].hi); spi_byte(vecs[v].lo);
      push_exp(vecs[v].exp_addr, vecs[v].exp_data);
      spi_byte(vecs[v].px);
      finish_txn("table", d0, 1);
    end

    // Address wrap 0xFFF -> 0x000
    d0 = done_cnt;
    csb_low();
    spi_byte(8'h50); spi_byte(8'h0F); spi_byte(8'hFF);
    push_exp(12'hFFF, 6'h01); push_exp(12'h000, 6'h02);
    spi_byte(8'h01); spi_byte(8'h02);
    finish_txn("wrap", d0, 1);

    // Bad command: ignored, busy held until release
    d0 = done_cnt;
    csb_low();
    spi_byte(8'h51); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h2A);
    check("badcmd_busy_held", {31'd0, busy}, 32'd1);
    finish_txn("badcmd", d0, 0);

    // Abort mid-byte: partial byte dropped
    d0 = done_cnt;
    csb_low();
    spi_byte(8'h50); spi_byte(8'h00); spi_byte(8'h10);
    push_exp(12'h010, 6'h2A);
    spi_byte(8'hAA);
    spi_bits(8'hF0, 4, 1'b0);
    finish_txn("abort", d0, 1);

    // CSb released on the same edge as the 8th bit
    d0 = done_cnt;
    csb_low();
    spi_byte(8'h50); spi_byte(8'h01); spi_byte(8'h23);
    push_exp(12'h123, 6'h07);
    spi_bits(8'h07, 8, 1'b1);
    finish_txn("release_last", d0, 1);

    // Reset during DATA with CSb held low
    d0 = done_cnt;
    csb_low();
    spi_byte(8'h50); spi_byte(8'h00); spi_byte(8'h20);
    push_exp(12'h020, 6'h11);
    spi_byte(8'h11);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_byte(8'h33); spi_byte(8'h44);
    check("rst_mid_not_busy", {31'd0, busy}, 32'd0);
    finish_txn("rst_mid", d0, 0);

    d0 = done_cnt;
    csb_low();
    spi_byte(8'h50); spi_byte(8'h03); spi_byte(8'h00);
    push_exp(12'h300, 6'h2A);
    spi_byte(8'h2A);
    finish_txn("post_reset", d0, 1);

    // Partial frame from address 0: three columns of 64 rows
    d0 = done_cnt;
    csb_low();
    spi_byte(8'h50); spi_byte(8'h00); spi_byte(8'h00);
    for (int a = 0; a < 192; a++) begin
      logic [11:0] aa;
      aa = 12'(a);
      push_exp(aa, aa[5:0]);
      spi_byte({2'b00, aa[5:0]});
    end
    finish_txn("frame", d0, 1);
    for (int col = 0; col < 3; col++) begin
      for (int row = 0; row < 64; row++) begin
        logic [5:0] c6, r6;
        c6 = 6'(col);
        r6 = 6'(row);
        check("frame_ram_row", {26'd0, ram_model[{c6, r6}]}, {26'd0, r6});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
